// File: rtl/fwd_pkg.sv
// Shared types and constants for the forwarding / hazard unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fwd_pkg;

  // Upper bound on register address width held in a shadow entry.
  // Narrower addresses are zero-extended into the dst field.
  localparam int MAX_ADDR_W = 8;

  // Forward select value that means "take the operand from the register file".
  localparam int SEL_REGFILE = 0;

  // One in-flight instruction as seen by the hazard logic.
  typedef struct packed {
    logic                  valid;
    logic                  wr;
    logic                  ld;
    logic [MAX_ADDR_W-1:0] dst;
  } shadowEntry_t;

  // Width of a per-port forward select: must encode 0..fwdStages.
  function automatic int selWidth(input int fwdStages);
    return (fwdStages < 1) ? 1 : $clog2(fwdStages + 1);
  endfunction

endpackage

// File: rtl/fwd_port_match.sv
// Per-read-port source match against the next-cycle producer positions.
// Latency: combinational.
// Backpressure: none; loadHit feeds the unit's load-use stall.
module fwd_port_match
  import fwd_pkg::*;
#(
  parameter int REG_ADDR_W         = 5,
  parameter int FWD_STAGES         = 2,
  parameter int SEL_W              = selWidth(FWD_STAGES),
  parameter bit ZERO_REG_HARDWIRED = 1'b1
) (
  input  logic [REG_ADDR_W-1:0]          src,
  input  shadowEntry_t [FWD_STAGES-1:0]  cands,
  output logic [SEL_W-1:0]               sel,
  output logic                           loadHit
);

  // cands[i] is the producer that will sit in post-EX stage i+1 when this
  // instruction reaches EX, so index 0 is the youngest producer.
  logic [FWD_STAGES-1:0] hit;
  logic                  srcLive;

  // A hardwired zero register is never produced, so it can never match.
  always_comb begin
    srcLive = 1'b1;
    if (ZERO_REG_HARDWIRED && (src == '0)) begin
      srcLive = 1'b0;
    end
  end

  // Candidate qualifies when it is a real register write to our source.
  always_comb begin
    hit = '0;
    for (int s = 0; s < FWD_STAGES; s++) begin
      hit[s] = srcLive & cands[s].valid & cands[s].wr &
               (cands[s].dst == MAX_ADDR_W'(src));
    end
  end

  // Oldest first, overwritten by younger matches: the youngest producer wins.
  // Select encoding counts down with age, stage s -> FWD_STAGES+1-s.
  always_comb begin
    sel     = SEL_W'(SEL_REGFILE);
    loadHit = 1'b0;
    for (int s = FWD_STAGES - 1; s >= 0; s--) begin
      if (hit[s]) begin
        sel     = SEL_W'(FWD_STAGES - s);
        loadHit = (s == 0) && cands[s].ld;
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forward-select and load-use stall generation from a shadow copy of in-flight writes.
// Latency: fwd_sel/ex_valid registered (valid in EX, one cycle after issue); stall combinational.
// Backpressure: stall holds PC and IF/ID and injects a bubble; flush overrides stall.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int REG_ADDR_W         = 5,
  parameter int NUM_RD_PORTS       = 2,
  parameter int FWD_STAGES         = 2,
  parameter int SEL_W              = selWidth(FWD_STAGES),
  parameter bit ZERO_REG_HARDWIRED = 1'b1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               id_valid,
  input  logic                               id_reg_write,
  input  logic                               id_is_load,
  input  logic [REG_ADDR_W-1:0]              id_write_reg,
  input  logic [NUM_RD_PORTS*REG_ADDR_W-1:0] id_read_regs,
  input  logic                               flush,
  output logic                               stall,
  output logic                               ex_valid,
  output logic [NUM_RD_PORTS*SEL_W-1:0]      fwd_sel
);

  // exSlot mirrors ID/EX; stg[k] mirrors post-EX stage k+1 (stg[0] = EX/MEM).
  shadowEntry_t                    exSlot;
  shadowEntry_t [FWD_STAGES-1:0]   stg;
  shadowEntry_t [FWD_STAGES-1:0]   cands;
  shadowEntry_t                    idEntry;
  logic [NUM_RD_PORTS-1:0]         loadHits;
  logic [NUM_RD_PORTS*SEL_W-1:0]   selNext;
  logic                            issue;

  // Producers as they will be positioned next cycle: EX moves to stage 1,
  // stage s-1 moves to stage s. The oldest stage retires and never forwards.
  always_comb begin
    cands    = '0;
    cands[0] = exSlot;
    for (int s = 1; s < FWD_STAGES; s++) begin
      cands[s] = stg[s-1];
    end
  end

  genvar p;
  generate
    for (p = 0; p < NUM_RD_PORTS; p++) begin : g_port
      fwd_port_match #(
        .REG_ADDR_W         (REG_ADDR_W),
        .FWD_STAGES         (FWD_STAGES),
        .SEL_W              (SEL_W),
        .ZERO_REG_HARDWIRED (ZERO_REG_HARDWIRED)
      ) u_match (
        .src     (id_read_regs[p*REG_ADDR_W +: REG_ADDR_W]),
        .cands   (cands),
        .sel     (selNext[p*SEL_W +: SEL_W]),
        .loadHit (loadHits[p])
      );
    end
  endgenerate

  // Load-use stall only when the youngest producer of some source is a load
  // still in EX; a killed ID instruction never stalls.
  always_comb begin
    stall = id_valid & ~flush & (|loadHits);
    issue = id_valid & ~stall & ~flush;
  end

  // Shadow image of the ID instruction as it would enter EX.
  always_comb begin
    idEntry       = '0;
    idEntry.valid = 1'b1;
    idEntry.wr    = id_reg_write;
    idEntry.ld    = id_is_load;
    idEntry.dst   = MAX_ADDR_W'(id_write_reg);
  end

  // Post-EX stages always advance; EX loads on issue or takes a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      exSlot  <= '0;
      stg     <= '0;
      fwd_sel <= '0;
    end else begin
      stg[0] <= exSlot;
      for (int k = 1; k < FWD_STAGES; k++) begin
        stg[k] <= stg[k-1];
      end
      if (issue) begin
        exSlot  <= idEntry;
        fwd_sel <= selNext;
      end else begin
        exSlot  <= '0;
        fwd_sel <= '0;
      end
    end
  end

  assign ex_valid = exSlot.valid;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench: default unit, a zero-register-not-hardwired unit sharing its
// stimulus, and a three-stage / three-port unit with its own stimulus.
module tb_fwd_hazard_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;

  // Shared stimulus for units A (default) and B (ZERO_REG_HARDWIRED = 0)
  logic       vld, wr, ld, fl;
  logic [4:0] dst;
  logic [9:0] rd;
  logic       stallA, exvA, stallB, exvB;
  logic [3:0] selA, selB;

  // Unit C: FWD_STAGES = 3, NUM_RD_PORTS = 3
  logic        vldC, wrC, ldC, flC;
  logic [4:0]  dstC;
  logic [14:0] rdC;
  logic        stallC, exvC;
  logic [5:0]  selC;

  int nCmp = 0;
  int nBad = 0;

  fwd_hazard_unit u_a (
    .clk(clk), .rst(rst), .id_valid(vld), .id_reg_write(wr), .id_is_load(ld),
    .id_write_reg(dst), .id_read_regs(rd), .flush(fl),
    .stall(stallA), .ex_valid(exvA), .fwd_sel(selA)
  );

  fwd_hazard_unit #(.ZERO_REG_HARDWIRED(1'b0)) u_b (
    .clk(clk), .rst(rst), .id_valid(vld), .id_reg_write(wr), .id_is_load(ld),
    .id_write_reg(dst), .id_read_regs(rd), .flush(fl),
    .stall(stallB), .ex_valid(exvB), .fwd_sel(selB)
  );

  fwd_hazard_unit #(.FWD_STAGES(3), .NUM_RD_PORTS(3)) u_c (
    .clk(clk), .rst(rst), .id_valid(vldC), .id_reg_write(wrC), .id_is_load(ldC),
    .id_write_reg(dstC), .id_read_regs(rdC), .flush(flC),
    .stall(stallC), .ex_valid(exvC), .fwd_sel(selC)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nBad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic v, input logic w, input logic l, input logic [4:0] d,
                     input logic [4:0] r0, input logic [4:0] r1, input logic f);
    vld = v; wr = w; ld = l; dst = d; rd = {r1, r0}; fl = f;
  endtask

  task automatic drvC(input logic v, input logic w, input logic l, input logic [4:0] d,
                      input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2);
    vldC = v; wrC = w; ldC = l; dstC = d; rdC = {r2, r1, r0}; flC = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    drv(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    drvC(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
    repeat (n) tick();
  endtask

  initial begin
    rst = 1'b1;
    idle(3);
    chk("rst_ex_valid", 32'(exvA), 32'd0);
    chk("rst_fwd_sel", 32'(selA), 32'd0);
    chk("rst_stall", 32'(stallA), 32'd0);
    rst = 1'b0;
    idle(1);

    // Back-to-back ALU dependency on r3
    drv(1, 1, 0, 5'd3, 5'd0, 5'd0, 0); tick();
    drv(1, 0, 0, 5'd0, 5'd3, 5'd9, 0); #1;
    chk("b2b_stall", 32'(stallA), 32'd0);
    tick();
    chk("b2b_sel", 32'(selA), 32'h2);
    chk("b2b_exv", 32'(exvA), 32'd1);
    idle(3);

    // One independent instruction between producer and consumer (port 1)
    drv(1, 1, 0, 5'd3, 5'd0, 5'd0, 0); tick();
    drv(1, 1, 0, 5'd10, 5'd0, 5'd0, 0); tick();
    drv(1, 0, 0, 5'd0, 5'd11, 5'd3, 0); tick();
    chk("gap1_sel", 32'(selA), 32'h4);
    idle(3);

    // Two independent instructions between: out of forwarding range
    drv(1, 1, 0, 5'd3, 5'd0, 5'd0, 0); tick();
    drv(1, 1, 0, 5'd10, 5'd0, 5'd0, 0); tick();
    drv(1, 1, 0, 5'd11, 5'd0, 5'd0, 0); tick();
    drv(1, 0, 0, 5'd0, 5'd0, 5'd3, 0); tick();
    chk("gap2_sel", 32'(selA), 32'h0);
    chk("gap2_exv", 32'(exvA), 32'd1);
    idle(3);

    // Two producers of r5: youngest wins
    drv(1, 1, 0, 5'd5, 5'd0, 5'd0, 0); tick();
    drv(1, 1, 0, 5'd5, 5'd0, 5'd0, 0); tick();
    drv(1, 0, 0, 5'd0, 5'd5, 5'd0, 0); tick();
    chk("dbl_sel", 32'(selA), 32'h2);
    idle(3);

    // Load-use: one-cycle stall, bubble, then forward from stage 2
    drv(1, 1, 1, 5'd7, 5'd0, 5'd0, 0); tick();
    drv(1, 0, 0, 5'd0, 5'd7, 5'd0, 0); #1;
    chk("lu_stall1", 32'(stallA), 32'd1);
    tick();
    chk("lu_bubble_exv", 32'(exvA), 32'd0);
    chk("lu_bubble_sel", 32'(selA), 32'h0);
    chk("lu_stall2", 32'(stallA), 32'd0);
    tick();
    chk("lu_exv", 32'(exvA), 32'd1);
    chk("lu_sel", 32'(selA), 32'h1);
    idle(3);

    // Load-use with the consumer flushed: no stall, bubble
    drv(1, 1, 1, 5'd7, 5'd0, 5'd0, 0); tick();
    drv(1, 0, 0, 5'd0, 5'd7, 5'd0, 1); #1;
    chk("luf_stall", 32'(stallA), 32'd0);
    tick();
    chk("luf_exv", 32'(exvA), 32'd0);
    chk("luf_sel", 32'(selA), 32'h0);
    idle(3);

    // r0 producer/consumer: hardwired zero never forwards, B does
    drv(1, 1, 0, 5'd0, 5'd0, 5'd0, 0); tick();
    drv(1, 0, 0, 5'd0, 5'd0, 5'd12, 0); #1;
    chk("r0_stallA", 32'(stallA), 32'd0);
    tick();
    chk("r0_selA", 32'(selA), 32'h0);
    chk("r0_selB", 32'(selB), 32'h2);
    chk("r0_exvB", 32'(exvB), 32'd1);
    idle(3);

    // Load to r0: only the non-hardwired unit stalls
    drv(1, 1, 1, 5'd0, 5'd0, 5'd0, 0); tick();
    drv(1, 0, 0, 5'd0, 5'd0, 5'd0, 0); #1;
    chk("r0ld_stallA", 32'(stallA), 32'd0);
    chk("r0ld_stallB", 32'(stallB), 32'd1);
    idle(3);

    // Reset mid-stream discards the r4 producer
    drv(1, 1, 0, 5'd4, 5'd0, 5'd0, 0); tick();
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("mrst_exv", 32'(exvA), 32'd0);
    drv(1, 0, 0, 5'd0, 5'd4, 5'd0, 0); tick();
    chk("mrst_sel", 32'(selA), 32'h0);
    chk("mrst_exv2", 32'(exvA), 32'd1);
    idle(3);

    // Three-stage unit: selects 3, 2, 1 by distance
    drvC(1, 1, 0, 5'd1, 5'd0, 5'd0, 5'd0); tick();
    drvC(1, 1, 0, 5'd2, 5'd0, 5'd0, 5'd0); tick();
    drvC(1, 1, 0, 5'd3, 5'd0, 5'd0, 5'd0); tick();
    drvC(1, 0, 0, 5'd0, 5'd3, 5'd2, 5'd1); #1;
    chk("n3_stall", 32'(stallC), 32'd0);
    tick();
    chk("n3_sel", 32'(selC), 32'b01_10_11);
    chk("n3_exv", 32'(exvC), 32'd1);
    idle(4);

    // Three-stage load-use: after the stall the load forwards with sel = 2
    drvC(1, 1, 1, 5'd6, 5'd0, 5'd0, 5'd0); tick();
    drvC(1, 0, 0, 5'd0, 5'd6, 5'd0, 5'd0); #1;
    chk("n3lu_stall", 32'(stallC), 32'd1);
    tick();
    chk("n3lu_bubble", 32'(exvC), 32'd0);
    tick();
    chk("n3lu_sel", 32'(selC), 32'b00_00_10);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
